// File: rtl/video_timing_pkg.sv
// Shared definitions for the video/bus timing generator.
// Holds the phase indices that place the bus strobes within a CPU cycle,
// the default NTSC/PAL line counts, the video page base addresses and a
// decoder that turns a phase index into the bus strobe levels.
package video_timing_pkg;

  // Edge positions inside one CPU cycle (phase counter values).
  localparam logic [3:0] PH_Q3_FALL_A   = 4'd4;
  localparam logic [3:0] PH_RAS_FALL_A  = 4'd4;
  localparam logic [3:0] PH_CAS_FALL_A  = 4'd5;
  localparam logic [3:0] PH_PHI0_RISE   = 4'd7;   // also Q3 and RAS_N/CAS_N rise
  localparam logic [3:0] PH_Q3_FALL_B   = 4'd11;
  localparam logic [3:0] PH_RAS_FALL_B  = 4'd11;
  localparam logic [3:0] PH_CAS_FALL_B  = 4'd12;
  localparam logic [3:0] PH_LDPS        = 4'd13;
  localparam logic [3:0] PH_LAST_SHORT  = 4'd13;
  localparam logic [3:0] PH_LAST_LONG   = 4'd15;

  localparam int V_TOTAL_NTSC_DEF = 262;
  localparam int V_TOTAL_PAL_DEF  = 312;

  localparam logic [15:0] TEXT_BASE_P1  = 16'h0400;
  localparam logic [15:0] TEXT_BASE_P2  = 16'h0800;
  localparam logic [15:0] HIRES_BASE_P1 = 16'h2000;
  localparam logic [15:0] HIRES_BASE_P2 = 16'h4000;

  typedef struct packed {
    logic phi0;
    logic q3;
    logic ras_n;
    logic cas_n;
    logic ldps_n;
  } bus_phase_t;

  typedef struct packed {
    logic hblank;
    logic vblank;
    logic hsync_n;
    logic vsync_n;
    logic color_burst;
    logic gr;
    logic hires;
  } line_flags_t;

  // Bus strobe levels for a given phase. The second half of the cycle
  // (phases 11..last) stretches naturally when the long cycle runs to 15.
  function automatic bus_phase_t decode_phase(input logic [3:0] ph);
    bus_phase_t d;
    d.phi0   = (ph >= PH_PHI0_RISE);
    d.q3     = (ph < PH_Q3_FALL_A) || ((ph >= PH_PHI0_RISE) && (ph < PH_Q3_FALL_B));
    d.ras_n  = !(((ph >= PH_RAS_FALL_A) && (ph < PH_PHI0_RISE)) || (ph >= PH_RAS_FALL_B));
    d.cas_n  = !(((ph >= PH_CAS_FALL_A) && (ph < PH_PHI0_RISE)) || (ph >= PH_CAS_FALL_B));
    d.ldps_n = (ph != PH_LDPS);
    return d;
  endfunction

endpackage

// File: rtl/video_addr_calc.sv
// Combinational video fetch address generator.
// Ports:
//   h_i     : cycle counter (column position incl. blanking)
//   v_i     : line counter
//   hires_i : effective hires mode for the line
//   pg2_i   : page 2 selected (PAGE2 && !STORE80)
//   addr_o  : 16-bit fetch address
module video_addr_calc
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 40,
  parameter int V_ACTIVE = 192
) (
  input  logic [6:0]  h_i,
  input  logic [8:0]  v_i,
  input  logic        hires_i,
  input  logic        pg2_i,
  output logic [15:0] addr_o
);

  localparam logic [6:0] H_ACT = 7'(H_ACTIVE);
  localparam logic [8:0] V_ACT = 9'(V_ACTIVE);

  logic [6:0]  col;
  logic [8:0]  vv;
  logic [5:0]  row;
  logic [15:0] base;
  logic [15:0] group_ofs;

  always_comb begin
    // Blanking columns re-walk the first columns so DRAM refresh keeps
    // covering every row during horizontal blank.
    col = (h_i >= H_ACT) ? (h_i - H_ACT) : h_i;
    // Lines past the active area fold back once; the frame is always
    // shorter than twice the active height, so one subtraction is enough.
    vv  = (v_i >= V_ACT) ? (v_i - V_ACT) : v_i;
    row = vv[8:3];
    // 40-byte stride for each group of eight character rows (vv >> 6).
    group_ofs = 16'(row[5:3]) * 16'd40;
    if (hires_i) begin
      base   = pg2_i ? HIRES_BASE_P2 : HIRES_BASE_P1;
      addr_o = base + {3'b000, vv[2:0], 10'b0} + {6'b0, row[2:0], 7'b0}
             + group_ofs + {9'b0, col};
    end else begin
      base   = pg2_i ? TEXT_BASE_P2 : TEXT_BASE_P1;
      addr_o = base + {6'b0, row[2:0], 7'b0} + group_ofs + {9'b0, col};
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Video and CPU bus timing generator driven from the 14.318 MHz clock.
// A 14-tick (16 on the last cycle of a line when LONG_CYCLE=1) phase
// counter produces the bus strobes; on each cycle boundary the H/V
// counters advance and all line-level outputs are re-registered.
// Ports:
//   CLK_14M, RESET_N                  : clock, async active-low reset
//   PAL_MODE                          : line count select, taken at frame wrap
//   TEXT_MODE..STORE80                : soft-switch states
//   PHI0, Q3, RAS_N, CAS_N, LDPS_N    : bus phases / shift-register load
//   H, V                              : cycle and line counters
//   HBLANK, VBLANK, HSYNC_N, VSYNC_N  : blanking and sync
//   COLOR_BURST, GR, HIRES            : burst gate and effective modes
//   VIDEO_ADDRESS                     : video fetch address
//   FRAME_START                       : one-tick pulse at frame origin
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL      = 65,
  parameter int H_ACTIVE     = 40,
  parameter int V_TOTAL_NTSC = V_TOTAL_NTSC_DEF,
  parameter int V_TOTAL_PAL  = V_TOTAL_PAL_DEF,
  parameter int V_ACTIVE     = 192,
  parameter int MIXED_LINE   = 160,
  parameter int HSYNC_START  = 49,
  parameter int HSYNC_LEN    = 4,
  parameter int VSYNC_START  = 224,
  parameter int VSYNC_LEN    = 4,
  parameter int LONG_CYCLE   = 1
) (
  input  logic        CLK_14M,
  input  logic        RESET_N,
  input  logic        PAL_MODE,
  input  logic        TEXT_MODE,
  input  logic        MIXED_MODE,
  input  logic        HIRES_MODE,
  input  logic        PAGE2,
  input  logic        STORE80,
  output logic        PHI0,
  output logic        Q3,
  output logic        RAS_N,
  output logic        CAS_N,
  output logic        LDPS_N,
  output logic [6:0]  H,
  output logic [8:0]  V,
  output logic        HBLANK,
  output logic        VBLANK,
  output logic        HSYNC_N,
  output logic        VSYNC_N,
  output logic        COLOR_BURST,
  output logic        GR,
  output logic        HIRES,
  output logic [15:0] VIDEO_ADDRESS,
  output logic        FRAME_START
);

  localparam logic [6:0] H_LAST   = 7'(H_TOTAL - 1);
  localparam logic [6:0] H_ACT    = 7'(H_ACTIVE);
  localparam logic [6:0] HS_BEGIN = 7'(HSYNC_START);
  localparam logic [6:0] HS_END   = 7'(HSYNC_START + HSYNC_LEN);
  localparam logic [6:0] CB_END   = 7'(HSYNC_START + HSYNC_LEN + 4);
  localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
  localparam logic [8:0] V_MIX    = 9'(MIXED_LINE);
  localparam logic [8:0] VS_BEGIN = 9'(VSYNC_START);
  localparam logic [8:0] VS_END   = 9'(VSYNC_START + VSYNC_LEN);
  localparam logic [8:0] VT_NTSC  = 9'(V_TOTAL_NTSC);
  localparam logic [8:0] VT_PAL   = 9'(V_TOTAL_PAL);

  localparam bus_phase_t BUS_RESET = '{phi0: 1'b0, q3: 1'b1, ras_n: 1'b1,
                                       cas_n: 1'b1, ldps_n: 1'b1};
  localparam line_flags_t FLAGS_RESET = '{hblank: 1'b0, vblank: 1'b0,
                                          hsync_n: 1'b1, vsync_n: 1'b1,
                                          color_burst: 1'b0, gr: 1'b0,
                                          hires: 1'b0};

  logic [3:0]  phase_q, phase_d, last_phase;
  logic [6:0]  h_q, h_d;
  logic [8:0]  v_q, v_d;
  logic        pal_q, pal_d;
  logic [8:0]  v_total;
  logic        boundary, h_wrap, v_wrap;
  bus_phase_t  bus_q, bus_d;
  line_flags_t flags_q, flags_d;
  logic [15:0] addr_q, addr_d;
  logic        frame_start_q, frame_start_d;
  logic        pg2;
  logic        mixed_text;

  // Counter next-state.
  always_comb begin
    last_phase = ((LONG_CYCLE != 0) && (h_q == H_LAST)) ? PH_LAST_LONG : PH_LAST_SHORT;
    boundary   = (phase_q == last_phase);
    phase_d    = boundary ? 4'd0 : phase_q + 4'd1;
    v_total    = pal_q ? VT_PAL : VT_NTSC;
    h_wrap     = (h_q == H_LAST);
    v_wrap     = (v_q == v_total - 9'd1);
    h_d        = h_q;
    v_d        = v_q;
    pal_d      = pal_q;
    if (boundary) begin
      if (h_wrap) begin
        h_d = 7'd0;
        if (v_wrap) begin
          v_d   = 9'd0;
          pal_d = PAL_MODE;   // line count only changes between frames
        end else begin
          v_d = v_q + 9'd1;
        end
      end else begin
        h_d = h_q + 7'd1;
      end
    end
  end

  // Line-level outputs are computed from the counter values being entered,
  // so the registered result is valid for the whole new cycle.
  always_comb begin
    pg2        = PAGE2 && !STORE80;
    mixed_text = MIXED_MODE && (v_d >= V_MIX) && (v_d < V_ACT);
    flags_d.hblank      = (h_d >= H_ACT);
    flags_d.vblank      = (v_d >= V_ACT);
    flags_d.hsync_n     = !((h_d >= HS_BEGIN) && (h_d < HS_END));
    flags_d.vsync_n     = !((v_d >= VS_BEGIN) && (v_d < VS_END));
    flags_d.color_burst = flags_d.hblank && (h_d >= HS_END) && (h_d < CB_END) && !TEXT_MODE;
    flags_d.gr          = !TEXT_MODE && !mixed_text;
    flags_d.hires       = flags_d.gr && HIRES_MODE;
    bus_d               = decode_phase(phase_d);
    frame_start_d       = boundary && h_wrap && v_wrap;
  end

  video_addr_calc #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_addr (
    .h_i     (h_d),
    .v_i     (v_d),
    .hires_i (flags_d.hires),
    .pg2_i   (pg2),
    .addr_o  (addr_d)
  );

  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      phase_q       <= 4'd0;
      h_q           <= 7'd0;
      v_q           <= 9'd0;
      pal_q         <= 1'b0;
      bus_q         <= BUS_RESET;
      flags_q       <= FLAGS_RESET;
      addr_q        <= TEXT_BASE_P1;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      h_q           <= h_d;
      v_q           <= v_d;
      pal_q         <= pal_d;
      bus_q         <= bus_d;
      frame_start_q <= frame_start_d;
      if (boundary) begin
        flags_q <= flags_d;
        addr_q  <= addr_d;
      end
    end
  end

  assign PHI0          = bus_q.phi0;
  assign Q3            = bus_q.q3;
  assign RAS_N         = bus_q.ras_n;
  assign CAS_N         = bus_q.cas_n;
  assign LDPS_N        = bus_q.ldps_n;
  assign H             = h_q;
  assign V             = v_q;
  assign HBLANK        = flags_q.hblank;
  assign VBLANK        = flags_q.vblank;
  assign HSYNC_N       = flags_q.hsync_n;
  assign VSYNC_N       = flags_q.vsync_n;
  assign COLOR_BURST   = flags_q.color_burst;
  assign GR            = flags_q.gr;
  assign HIRES         = flags_q.hires;
  assign VIDEO_ADDRESS = addr_q;
  assign FRAME_START   = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen. The geometry is scaled down (12 cycles
// per line, 80/96 lines per frame) so several whole frames fit in a short
// run; the address layout constants are unchanged.
module tb_video_timing_gen;

  localparam int HT  = 12;
  localparam int HA  = 8;
  localparam int VTN = 80;
  localparam int VTP = 96;
  localparam int VA  = 72;
  localparam int ML  = 64;
  localparam int HSS = 9;
  localparam int HSL = 2;
  localparam int VSS = 74;
  localparam int VSL = 3;
  localparam int LC  = 1;
  localparam int L   = (HT - 1) * 14 + ((LC != 0) ? 16 : 14);

  typedef logic [44:0] vec_t;

  typedef struct {
    bit          tx, mx, hr, p2, s80;
    int          v, h;
    logic [15:0] addr;
    bit          gr, hres;
  } rec_t;

  logic        CLK_14M, RESET_N, PAL_MODE;
  logic        TEXT_MODE, MIXED_MODE, HIRES_MODE, PAGE2, STORE80;
  logic        PHI0, Q3, RAS_N, CAS_N, LDPS_N;
  logic [6:0]  H;
  logic [8:0]  V;
  logic        HBLANK, VBLANK, HSYNC_N, VSYNC_N, COLOR_BURST, GR, HIRES;
  logic [15:0] VIDEO_ADDRESS;
  logic        FRAME_START;

  video_timing_gen #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL_NTSC(VTN), .V_TOTAL_PAL(VTP),
    .V_ACTIVE(VA), .MIXED_LINE(ML), .HSYNC_START(HSS), .HSYNC_LEN(HSL),
    .VSYNC_START(VSS), .VSYNC_LEN(VSL), .LONG_CYCLE(LC)
  ) dut (
    .CLK_14M(CLK_14M), .RESET_N(RESET_N), .PAL_MODE(PAL_MODE),
    .TEXT_MODE(TEXT_MODE), .MIXED_MODE(MIXED_MODE), .HIRES_MODE(HIRES_MODE),
    .PAGE2(PAGE2), .STORE80(STORE80),
    .PHI0(PHI0), .Q3(Q3), .RAS_N(RAS_N), .CAS_N(CAS_N), .LDPS_N(LDPS_N),
    .H(H), .V(V), .HBLANK(HBLANK), .VBLANK(VBLANK),
    .HSYNC_N(HSYNC_N), .VSYNC_N(VSYNC_N), .COLOR_BURST(COLOR_BURST),
    .GR(GR), .HIRES(HIRES), .VIDEO_ADDRESS(VIDEO_ADDRESS),
    .FRAME_START(FRAME_START)
  );

  initial begin
    CLK_14M = 1'b0;
    forever #5 CLK_14M = ~CLK_14M;
  end

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  vec_t exp_q[$];
  vec_t rst_vec;

  // ---------------- reference model (tick offset within a line) ----------
  int          lt, mv;
  bit          mpal;
  bit          e_hb, e_vb, e_hs, e_vs, e_cb, e_gr, e_hr, e_fs;
  logic [15:0] e_addr;

  function automatic int f_h(input int t);
    return (t / 14 > HT - 1) ? HT - 1 : t / 14;
  endfunction

  function automatic int f_ph(input int t);
    return t - 14 * f_h(t);
  endfunction

  function automatic logic [15:0] model_addr(input int h, input int v, input bit hr, input bit pg2);
    int vv, col, row, a;
    vv  = v % VA;
    col = (h < HA) ? h : h - HA;
    row = vv / 8;
    if (hr) a = (pg2 ? 'h4000 : 'h2000) + 1024 * (vv % 8) + 128 * (row % 8) + 40 * (vv / 64) + col;
    else    a = (pg2 ? 'h0800 : 'h0400) + 128 * (row % 8) + 40 * (row / 8) + col;
    return 16'(a);
  endfunction

  function automatic vec_t model_vec();
    int ph;
    bit phi0, q3, ras_n, cas_n, ldps_n;
    ph     = f_ph(lt);
    phi0   = (ph >= 7);
    q3     = (ph <= 3) || (ph >= 7 && ph <= 10);
    ras_n  = !((ph >= 4 && ph <= 6) || ph >= 11);
    cas_n  = !((ph >= 5 && ph <= 6) || ph >= 12);
    ldps_n = (ph != 13);
    return {phi0, q3, ras_n, cas_n, ldps_n, 7'(f_h(lt)), 9'(mv),
            e_hb, e_vb, e_hs, e_vs, e_cb, e_gr, e_hr, e_addr, e_fs};
  endfunction

  task automatic model_reset();
    lt = 0; mv = 0; mpal = 0;
    e_hb = 0; e_vb = 0; e_hs = 1; e_vs = 1; e_cb = 0; e_gr = 0; e_hr = 0;
    e_addr = 16'h0400; e_fs = 0;
  endtask

  task automatic model_step();
    int h0, h;
    bit bnd;
    h0  = f_h(lt);
    bnd = (f_ph(lt) == ((h0 == HT - 1 && LC != 0) ? 15 : 13));
    lt  = lt + 1;
    if (lt == L) begin
      lt = 0;
      if (mv == (mpal ? VTP : VTN) - 1) begin
        mv = 0;
        mpal = PAL_MODE;
      end else begin
        mv = mv + 1;
      end
    end
    e_fs = bnd && lt == 0 && mv == 0;
    if (bnd) begin
      h      = f_h(lt);
      e_hb   = (h >= HA);
      e_vb   = (mv >= VA);
      e_hs   = !(h >= HSS && h < HSS + HSL);
      e_vs   = !(mv >= VSS && mv < VSS + VSL);
      e_cb   = e_hb && h >= HSS + HSL && h < HSS + HSL + 4 && !TEXT_MODE;
      e_gr   = !TEXT_MODE && !(MIXED_MODE && mv >= ML && mv < VA);
      e_hr   = e_gr && HIRES_MODE;
      e_addr = model_addr(h, mv, e_hr, PAGE2 && !STORE80);
    end
  endtask

  // Model advances on every edge and pushes the expected output vector.
  initial begin
    model_reset();
    forever begin
      @(posedge CLK_14M);
      cyc = cyc + 1;
      if (!RESET_N) model_reset();
      else model_step();
      exp_q.push_back(model_vec());
    end
  end

  function automatic vec_t dut_vec();
    return {PHI0, Q3, RAS_N, CAS_N, LDPS_N, H, V, HBLANK, VBLANK, HSYNC_N,
            VSYNC_N, COLOR_BURST, GR, HIRES, VIDEO_ADDRESS, FRAME_START};
  endfunction

  // Scoreboard: one comparison per tick, away from the active edge.
  initial begin
    vec_t ev;
    forever begin
      @(negedge CLK_14M);
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL scoreboard_empty cycle=%0d", cyc);
      end else begin
        ev = exp_q.pop_front();
        if (!RESET_N) ev = rst_vec;
        if (dut_vec() !== ev) begin
          failures = failures + 1;
          $display("FAIL tick cycle=%0d actual=%h required=%h", cyc, dut_vec(), ev);
        end
      end
    end
  end

  // Sync extents and frame-start spacing, observed on the DUT outputs.
  bit mon_en = 0;
  int hs_min = 999, hs_max = -1, vs_min = 999, vs_max = -1;
  int fs_times[$];
  initial begin
    forever begin
      @(negedge CLK_14M);
      if (mon_en && RESET_N) begin
        if (!HSYNC_N) begin
          if (int'(H) < hs_min) hs_min = int'(H);
          if (int'(H) > hs_max) hs_max = int'(H);
        end
        if (!VSYNC_N) begin
          if (int'(V) < vs_min) vs_min = int'(V);
          if (int'(V) > vs_max) vs_max = int'(V);
        end
        if (FRAME_START) fs_times.push_back(cyc);
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("check %s value=%0d ok", name, act);
    end
  endtask

  task automatic wait_pos(input int v, input int h, input int ph, output bit ok);
    ok = 0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge CLK_14M);
      if (mv == v && f_h(lt) == h && f_ph(lt) == ph) begin
        ok = 1;
        break;
      end
    end
  endtask

  rec_t tbl[$];
  task automatic add(input bit tx, mx, hr, p2, s80, input int v, h,
                     input logic [15:0] addr, input bit gr, hres);
    rec_t r;
    r.tx = tx; r.mx = mx; r.hr = hr; r.p2 = p2; r.s80 = s80;
    r.v = v; r.h = h; r.addr = addr; r.gr = gr; r.hres = hres;
    tbl.push_back(r);
  endtask

  initial begin
    bit ok;
    rst_vec = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 7'd0, 9'd0, 1'b0, 1'b0, 1'b1,
               1'b1, 1'b0, 1'b0, 1'b0, 16'h0400, 1'b0};
    RESET_N = 0; PAL_MODE = 0;
    TEXT_MODE = 1; MIXED_MODE = 0; HIRES_MODE = 0; PAGE2 = 0; STORE80 = 0;

    //   tx mx hr p2 s80  V   H   addr      gr hires
    // frame 1 (NTSC)
    add(1, 0, 0, 0, 0,   0,  0, 16'h0400, 0, 0);
    add(1, 0, 0, 0, 0,   0,  7, 16'h0407, 0, 0);
    add(1, 0, 0, 0, 0,   0,  8, 16'h0400, 0, 0);
    add(1, 0, 0, 0, 0,   8,  0, 16'h0480, 0, 0);
    add(1, 0, 0, 0, 0,  40,  0, 16'h0680, 0, 0);
    add(1, 0, 0, 1, 0,  41,  3, 16'h0A83, 0, 0);
    add(0, 1, 1, 0, 0,  63,  0, 16'h3F80, 1, 1);
    add(0, 1, 1, 0, 0,  64,  0, 16'h0428, 0, 0);
    add(0, 1, 1, 0, 0,  71,  0, 16'h0428, 0, 0);
    add(0, 1, 1, 0, 0,  72,  0, 16'h2000, 1, 1);
    add(1, 0, 0, 0, 0,  79,  3, 16'h0403, 0, 0);
    // frame 2 (PAL, latched at its start)
    add(0, 0, 1, 1, 0,   0,  0, 16'h4000, 1, 1);
    add(0, 0, 1, 1, 0,   1,  0, 16'h4400, 1, 1);
    add(0, 0, 1, 1, 1,   1,  2, 16'h2402, 1, 1);
    add(0, 0, 1, 0, 0,  73,  0, 16'h2400, 1, 1);
    add(0, 0, 0, 0, 0,  90,  4, 16'h0504, 1, 0);
    add(1, 0, 0, 0, 0,  95, 11, 16'h0503, 0, 0);
    // frame 3 origin after the PAL frame
    add(1, 0, 0, 0, 0,   0,  0, 16'h0400, 0, 0);

    repeat (3) @(negedge CLK_14M);
    checks = checks + 1;
    if (dut_vec() !== rst_vec) begin
      failures = failures + 1;
      $display("FAIL reset_state actual=%h required=%h", dut_vec(), rst_vec);
    end else $display("reset_state %h ok", dut_vec());
    #2 RESET_N = 1;
    mon_en = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      TEXT_MODE = tbl[i].tx; MIXED_MODE = tbl[i].mx; HIRES_MODE = tbl[i].hr;
      PAGE2 = tbl[i].p2; STORE80 = tbl[i].s80;
      wait_pos(tbl[i].v, tbl[i].h, 0, ok);
      checks = checks + 1;
      if (!ok) begin
        failures = failures + 1;
        $display("FAIL vec%0d timeout waiting V=%0d H=%0d", i, tbl[i].v, tbl[i].h);
      end else if ({VIDEO_ADDRESS, GR, HIRES} !== {tbl[i].addr, tbl[i].gr, tbl[i].hres}) begin
        failures = failures + 1;
        $display("FAIL vec%0d V=%0d H=%0d actual addr=%h gr=%b hires=%b required addr=%h gr=%b hires=%b",
                 i, tbl[i].v, tbl[i].h, VIDEO_ADDRESS, GR, HIRES, tbl[i].addr, tbl[i].gr, tbl[i].hres);
      end else begin
        $display("vec%0d V=%0d H=%0d addr=%h gr=%b hires=%b ok",
                 i, tbl[i].v, tbl[i].h, VIDEO_ADDRESS, GR, HIRES);
      end
      if (i == 0) PAL_MODE = 1;   // mid-frame change, effective from frame 2
    end

    // Asynchronous reset in the middle of a graphics line.
    mon_en = 0;
    TEXT_MODE = 0; MIXED_MODE = 0; HIRES_MODE = 1; PAGE2 = 1; STORE80 = 0;
    wait_pos(50, 5, 9, ok);
    chk("reach_reset_point", int'(ok), 1);
    #2 RESET_N = 0;
    #1;
    checks = checks + 1;
    if (dut_vec() !== rst_vec) begin
      failures = failures + 1;
      $display("FAIL async_reset actual=%h required=%h", dut_vec(), rst_vec);
    end else $display("async_reset %h ok", dut_vec());
    repeat (3) @(negedge CLK_14M);
    #2 RESET_N = 1;
    repeat (2 * L) @(negedge CLK_14M);

    chk("hsync_first_h", hs_min, HSS);
    chk("hsync_last_h", hs_max, HSS + HSL - 1);
    chk("vsync_first_v", vs_min, VSS);
    chk("vsync_last_v", vs_max, VSS + VSL - 1);
    chk("frame_start_count", fs_times.size(), 3);
    if (fs_times.size() >= 3) begin
      chk("frame_ticks_ntsc", fs_times[1] - fs_times[0], VTN * L);
      chk("frame_ticks_pal", fs_times[2] - fs_times[1], VTP * L);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
